// File: rtl/raster_scan_reader_if.sv
// Signal bundle between the raster scan reader, its frame memory read port and the VGA DAC pins.
interface raster_scan_reader_if;
    logic [18:0] rd_addr;
    logic        rd_data;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic        VGA_CLK;
    logic        frame_start;
    logic [9:0]  h_pos;
    logic [9:0]  v_pos;

    modport master (
        output rd_addr,
        input  rd_data,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        output frame_start, h_pos, v_pos
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        input  frame_start, h_pos, v_pos
    );
endinterface

// File: rtl/raster_scan_reader.sv
// Walks the VGA raster, fetches one pixel bit per pixel period from the frame memory and
// drives RGB, sync, blank and a per-frame start pulse through a one-pixel output pipeline.
module raster_scan_reader #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          CLK_DIV  = 2,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    raster_scan_reader_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_n_q, blank_n_d;
    logic             vclk_q, vclk_d;
    logic             fs_q, fs_d;

    logic pix_en;
    logic active;
    logic h_last;
    logic v_last;
    logic in_hsync;
    logic in_vsync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vclk_q    <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            vclk_q    <= vclk_d;
            fs_q      <= fs_d;
        end
    end

    always_comb begin
        pix_en    = (div_cnt_q == DIV_LAST);
        h_last    = (h_cnt_q == H_LAST);
        v_last    = (v_cnt_q == V_LAST);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_hsync  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        in_vsync  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

        div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
        // VGA_CLK tracks the divider phase that the register holds after this edge
        vclk_d    = (div_cnt_d >= DIV_HALF);

        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        fs_d      = 1'b0;

        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // Output stage shows the pixel the counters pointed at before this edge
            rgb_d     = (active && vga.rd_data) ? FG_COLOR : 24'h000000;
            hs_d      = ~in_hsync;
            vs_d      = ~in_vsync;
            blank_n_d = active;
            fs_d      = h_last && v_last;
        end
    end

    assign vga.rd_addr     = active ? (19'(v_cnt_q) * 19'(H_ACTIVE) + 19'(h_cnt_q)) : 19'd0;
    assign vga.VGA_R       = rgb_q[23:16];
    assign vga.VGA_G       = rgb_q[15:8];
    assign vga.VGA_B       = rgb_q[7:0];
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_CLK     = vclk_q;
    assign vga.frame_start = fs_q;
    assign vga.h_pos       = h_cnt_q;
    assign vga.v_pos       = v_cnt_q;
endmodule

// File: tb/tb_raster_scan_reader.sv
// Bench for raster_scan_reader on a shrunken raster so whole frames fit in a short run;
// a pixel-index model checks every output on every falling edge.
module tb_raster_scan_reader;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSY = 4;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int CD  = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FRAME  = HT * VT * CD;
    localparam int TARGET = 3 * HA + 5;
    localparam longint FG = 64'hFFFFFF;

    logic clk = 1'b0;
    logic reset;
    raster_scan_reader_if vif();

    raster_scan_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(CD), .FG_COLOR(24'hFFFFFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vif.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int unsigned edges = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Frame memory: a single lit pixel at (5,3)
    initial begin
        vif.rd_data = 1'b0;
        forever begin
            @(negedge clk);
            vif.rd_data = (vif.rd_addr == 19'(TARGET));
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    longint rgb_now;
    int m_n, m_h, m_v, m_p, m_hp, m_vp;
    bit m_act;

    always @(negedge clk) begin
        if (chk_en) begin
            rgb_now = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
            chk("sync_n", vif.VGA_SYNC_N, 0);
            if (reset) begin
                chk("rst_rgb", rgb_now, 0);
                chk("rst_hs", vif.VGA_HS, 1);
                chk("rst_vs", vif.VGA_VS, 1);
                chk("rst_blank", vif.VGA_BLANK_N, 0);
                chk("rst_vclk", vif.VGA_CLK, 0);
                chk("rst_fs", vif.frame_start, 0);
                chk("rst_h", vif.h_pos, 0);
                chk("rst_v", vif.v_pos, 0);
                chk("rst_addr", vif.rd_addr, 0);
            end else begin
                m_n = int'(edges) / CD;
                m_h = m_n % HT;
                m_v = (m_n / HT) % VT;
                chk("h_pos", vif.h_pos, m_h);
                chk("v_pos", vif.v_pos, m_v);
                chk("rd_addr", vif.rd_addr, (m_h < HA && m_v < VA) ? m_v * HA + m_h : 0);
                chk("vga_clk", vif.VGA_CLK, ((int'(edges) % CD) >= CD / 2) ? 1 : 0);
                chk("frame_start", vif.frame_start,
                    (m_n > 0 && int'(edges) % CD == 0 && m_n % (HT * VT) == 0) ? 1 : 0);
                if (m_n == 0) begin
                    chk("pre_rgb", rgb_now, 0);
                    chk("pre_hs", vif.VGA_HS, 1);
                    chk("pre_vs", vif.VGA_VS, 1);
                    chk("pre_blank", vif.VGA_BLANK_N, 0);
                end else begin
                    m_p  = m_n - 1;
                    m_hp = m_p % HT;
                    m_vp = (m_p / HT) % VT;
                    m_act = (m_hp < HA) && (m_vp < VA);
                    chk("rgb", rgb_now, (m_act && (m_vp * HA + m_hp == TARGET)) ? FG : 0);
                    chk("hs", vif.VGA_HS, (m_hp >= HA + HFP && m_hp < HA + HFP + HSY) ? 0 : 1);
                    chk("vs", vif.VGA_VS, (m_vp >= VA + VFP && m_vp < VA + VFP + VSY) ? 0 : 1);
                    chk("blank_n", vif.VGA_BLANK_N, m_act ? 1 : 0);
                end
            end
        end
    end

    task automatic wait_pos(input int h, input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            @(negedge clk);
            if (vif.h_pos == 10'(h) && vif.v_pos == 10'(v)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_pos", ok, 1);
    endtask

    task automatic wait_fs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vif.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fs_seen", ok, 1);
    endtask

    int cnt_blank, cnt_hs, cnt_vs, cnt_white, cnt_fs;
    int hs_fall_h, vs_fall_h, vs_fall_v, white_h, white_v;
    bit prev_hs, prev_vs, got_hs, got_vs, got_white, fs_ok;

    initial begin
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("lit_rst_blank", vif.VGA_BLANK_N, 0);
        chk("lit_rst_hs", vif.VGA_HS, 1);
        chk("lit_rst_vs", vif.VGA_VS, 1);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("lit_h_after_1clk", vif.h_pos, 0);
        chk("lit_blank_before_pix", vif.VGA_BLANK_N, 0);
        chk("lit_hs_before_pix", vif.VGA_HS, 1);
        @(negedge clk);
        chk("lit_h_after_2clk", vif.h_pos, 1);

        // One whole frame measured from a frame_start pulse
        wait_fs(2 * FRAME + 10, fs_ok);
        cnt_blank = 0; cnt_hs = 0; cnt_vs = 0; cnt_white = 0; cnt_fs = 0;
        got_hs = 0; got_vs = 0; got_white = 0;
        hs_fall_h = -1; vs_fall_h = -1; vs_fall_v = -1; white_h = -1; white_v = -1;
        prev_hs = vif.VGA_HS; prev_vs = vif.VGA_VS;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (vif.VGA_BLANK_N) cnt_blank++;
            if (!vif.VGA_HS) cnt_hs++;
            if (!vif.VGA_VS) cnt_vs++;
            if (vif.frame_start) cnt_fs++;
            if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} == 24'hFFFFFF) begin
                cnt_white++;
                if (!got_white) begin
                    got_white = 1; white_h = int'(vif.h_pos); white_v = int'(vif.v_pos);
                end
            end
            if (prev_hs && !vif.VGA_HS && !got_hs) begin
                got_hs = 1; hs_fall_h = int'(vif.h_pos);
            end
            if (prev_vs && !vif.VGA_VS && !got_vs) begin
                got_vs = 1; vs_fall_h = int'(vif.h_pos); vs_fall_v = int'(vif.v_pos);
            end
            prev_hs = vif.VGA_HS;
            prev_vs = vif.VGA_VS;
        end
        chk("lit_blank_clks", cnt_blank, 256);
        chk("lit_hs_low_clks", cnt_hs, 120);
        chk("lit_vs_low_clks", cnt_vs, 100);
        chk("lit_white_clks", cnt_white, 2);
        chk("lit_fs_per_frame", cnt_fs, 1);
        chk("lit_hs_fall_h", hs_fall_h, 19);
        chk("lit_vs_fall_h", vs_fall_h, 1);
        chk("lit_vs_fall_v", vs_fall_v, 10);
        chk("lit_white_h", white_h, 6);
        chk("lit_white_v", white_v, 3);
        @(negedge clk);
        chk("lit_fs_period", vif.frame_start, 1);

        wait_pos(5, 3);
        chk("lit_addr_5_3", vif.rd_addr, 53);
        wait_pos(15, 7);
        chk("lit_addr_last", vif.rd_addr, 127);
        wait_pos(16, 0);
        chk("lit_addr_16_0", vif.rd_addr, 0);

        // Asynchronous reset in the middle of an active line
        wait_pos(12, 6);
        chk("lit_blank_mid", vif.VGA_BLANK_N, 1);
        #1 reset = 1'b1;
        #1;
        chk("lit_async_h", vif.h_pos, 0);
        chk("lit_async_v", vif.v_pos, 0);
        chk("lit_async_blank", vif.VGA_BLANK_N, 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_fs(FRAME + 10, fs_ok);
        chk("lit_fs_after_rst", int'(edges), FRAME);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raster_scan_reader.md
Name: raster_scan_reader

Overview:
- Read side of the 1-bit pixel frame memory that the line drawer and animation controller write into.
- Walks a 640x480 VGA raster at one pixel per CLK_DIV clocks and issues read addresses to the frame memory.
- Turns the returned pixel bit into 24-bit RGB with VGA sync and blank signals, and emits a one-clock frame_start pulse.
- frame_start lets writers pace animation frames from the raster.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; must be >= 2
- FG_COLOR, 24'hFFFFFF, RGB output when the pixel bit is 1 (bit 0 gives 24'h000000)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- rd_addr  out  19  frame memory address, row-major: v*H_ACTIVE+h
- rd_data  in  1  pixel bit, valid one clk after rd_addr changes
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  high during the active region
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  pixel clock
- frame_start  out  1  one-clk pulse at the start of each frame
- h_pos  out  10  current horizontal counter (debug/test)
- v_pos  out  10  current vertical counter (debug/test)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is high for exactly the one clk in which div_cnt == CLK_DIV-1.
  - VGA_CLK is registered: high when div_cnt >= CLK_DIV/2.
- Counters advance only on pix_en:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1, on the same edge that h_cnt wraps.
  - h_pos/v_pos = h_cnt/v_cnt.
- Address:
  - rd_addr is combinational from the counters: v_cnt*H_ACTIVE + h_cnt when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, else 0.
  - Maximum value is 307199.
  - Counters change 2+ clks before the next pix_en, so rd_data is stable at that pix_en.
- Output stage: registered, updates only on pix_en, and reflects the counters as they were before that edge (one-pixel pipeline).
  - active = h < H_ACTIVE and v < V_ACTIVE.
  - {VGA_R,VGA_G,VGA_B} = active ? (rd_data ? FG_COLOR : 0) : 0.
  - VGA_BLANK_N = active.
  - VGA_HS = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (h = 656..751).
  - VGA_VS = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (v = 490..491).
- frame_start:
  - Registered; high for exactly one clk, on the clk following the pix_en edge that moves the counters to (0,0).
  - Never high for more than one clk per frame.
  - Not asserted for the (0,0) state entered by reset.
- Reset (async, any time, including mid-line or mid-frame):
  - div_cnt, h_cnt, v_cnt = 0; RGB = 0; VGA_HS = 1; VGA_VS = 1; VGA_BLANK_N = 0; VGA_CLK = 0; frame_start = 0.
  - After release, the first pix_en is in clk CLK_DIV after release, and the raster restarts at (0,0).
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV = 840000 clks with defaults.
- No write path. Simultaneous writes to the memory are the memory's concern; the reader shows whatever the memory returns.

Test Plan:
- Reset held 5 clks, then released → outputs at reset values; first h_cnt increment in clk 2 after release; VGA_HS=1, VGA_BLANK_N=0 until first pix_en.
- Run one line → VGA_BLANK_N high for exactly 640 pixels (1280 clks); VGA_HS low exactly 96 pixels, starting at h=656; line period 1600 clks.
- Run one full frame → VGA_VS low for exactly 2 lines (3200 clks) starting at v=490; frame_start pulses once per 840000 clks, width 1 clk.
- Memory model returns 1 only at address 640*10+20 → RGB = 24'hFFFFFF for exactly the one pixel period at (20,10), 0 elsewhere; rd_addr = 0 throughout blanking.
- Check rd_addr at (639,479) → 307199; at (640,0) → 0.
- Assert reset mid-frame at (300,200) → outputs return to reset values asynchronously; after release, raster restarts at (0,0); no frame_start until the following wrap.
